fifo_stream_ctrl: RTL and testbench

FIFO_STREAM_CTRL -- requirements
Module: fifo_stream_ctrl

---
 rtl/fifo_stream_ctrl.sv | 131 +++++++++++++
 tb/tb_fifo_stream_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_ctrl.sv
`default_nettype none

`ifndef ADDR_FIFO
`define ADDR_FIFO 3
`endif
`ifndef WID_FIFO
`define WID_FIFO 16
`endif
`ifndef DEP_FIFO
`define DEP_FIFO 8
`endif

// ============================================================================
// Module   : fifo_stream_ctrl
// Purpose  : FIFO controller driving an external synchronous memory, with a
//            two-entry output buffer (head + skid) that turns the one-cycle
//            memory read latency into a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_ctrl #(
    parameter int ADDR_W = `ADDR_FIFO,
    parameter int WID    = `WID_FIFO,
    parameter int DEP    = `DEP_FIFO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WID-1:0]    wr_data,
    output logic              full,
    output logic              wr_ovf,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WID-1:0]    rd_data,
    output logic [ADDR_W+1:0] count,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_we,
    output logic [WID-1:0]    mem_din,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_re,
    input  logic [WID-1:0]    mem_dout
);

    localparam logic [ADDR_W:0] DEP_CNT = (ADDR_W+1)'(DEP);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              inflight;
    logic [1:0]        occ;
    logic [WID-1:0]    head;
    logic [WID-1:0]    skid;

    logic              push;
    logic              pop;
    logic [2:0]        level;
    logic [1:0]        occ_n;
    logic [WID-1:0]    head_n;
    logic [WID-1:0]    skid_n;

    // Handshake decode, memory port drive and status flags
    always_comb begin
        full      = (mem_cnt == DEP_CNT);
        push      = wr_en & ~full;
        rd_valid  = (occ != 2'd0);
        pop       = rd_valid & rd_ready;
        rd_data   = head;
        // Words that will occupy the buffer once this cycle's pop is applied;
        // a new read is only issued when it is guaranteed a free slot.
        level     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        mem_we    = push & ~rst;
        mem_waddr = wptr;
        mem_din   = wr_data;
        mem_re    = (mem_cnt != '0) & (level < 3'd2) & ~rst;
        mem_raddr = rptr;
        count     = (ADDR_W+2)'(mem_cnt) + (ADDR_W+2)'(inflight) + (ADDR_W+2)'(occ);
    end

    // Output buffer next state: pop shifts skid into head, then the returning
    // memory word lands in the first free entry.
    always_comb begin
        head_n = head;
        skid_n = skid;
        occ_n  = occ;
        if (pop) begin
            head_n = skid;
            occ_n  = occ - 2'd1;
        end
        if (inflight) begin
            if (occ_n == 2'd0) begin
                head_n = mem_dout;
            end else begin
                skid_n = mem_dout;
            end
            occ_n = occ_n + 2'd1;
        end
    end

    // Pointer, occupancy, in-flight tracking and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            wr_ovf   <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (mem_re) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !mem_re) begin
                mem_cnt <= mem_cnt + 1'b1;
            end else if (!push && mem_re) begin
                mem_cnt <= mem_cnt - 1'b1;
            end
            inflight <= mem_re;
            occ      <= occ_n;
            head     <= head_n;
            skid     <= skid_n;
            wr_ovf   <= wr_en & full;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_ctrl.sv
`default_nettype none

// ============================================================================
// Module   : tb_fifo_stream_ctrl
// Purpose  : Directed self-checking bench for fifo_stream_ctrl (DEP=8,
//            ADDR_W=3, WID=16) with a synchronous memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        wr_ovf;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [4:0]  count;
    logic [2:0]  mem_waddr;
    logic        mem_we;
    logic [15:0] mem_din;
    logic [2:0]  mem_raddr;
    logic        mem_re;
    logic [15:0] mem_dout;

    logic [15:0] mem [8];

    int total;
    int bad;

    fifo_stream_ctrl #(
        .ADDR_W (3),
        .WID    (16),
        .DEP    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .wr_ovf    (wr_ovf),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .count     (count),
        .mem_waddr (mem_waddr),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_raddr (mem_raddr),
        .mem_re    (mem_re),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after mem_re is sampled
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_din;
        if (mem_re) mem_dout <= mem[mem_raddr];
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int p;
        int first_c;
        int last_c;
        int maxocc;

        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 16'h5555;
        rd_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // Reset state, with a push request held during reset
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_mem_re",   32'(mem_re),   32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_full",     32'(full),     32'd0);
        check("rst_wr_ovf",   32'(wr_ovf),   32'd0);
        wr_en = 1'b0;
        rst   = 1'b0;
        tick();
        check("idle_count", 32'(count), 32'd0);

        // Single push into empty FIFO: valid after the second edge
        wr_en   = 1'b1;
        wr_data = 16'h0011;
        tick();
        wr_en = 1'b0;
        check("lat_count_e0", 32'(count),    32'd1);
        check("lat_valid_e0", 32'(rd_valid), 32'd0);
        tick();
        check("lat_valid_e1", 32'(rd_valid), 32'd0);
        tick();
        check("lat_valid_e2", 32'(rd_valid), 32'd1);
        check("lat_data",     32'(rd_data),  32'h0011);
        check("lat_count",    32'(count),    32'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("pop_valid", 32'(rd_valid), 32'd0);
        check("pop_count", 32'(count),    32'd0);

        // Fill: 8 words in memory plus 2 in the buffer makes it full
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h0100 + 16'(i);
            tick();
        end
        check("fill_count", 32'(count),   32'd10);
        check("fill_full",  32'(full),    32'd1);
        check("fill_head",  32'(rd_data), 32'h0100);
        check("fill_ovf0",  32'(wr_ovf),  32'd0);
        wr_data = 16'hDEAD;
        tick();
        check("ovf_pulse", 32'(wr_ovf), 32'd1);
        check("ovf_count", 32'(count),  32'd10);
        wr_en = 1'b0;
        tick();
        check("ovf_clear", 32'(wr_ovf), 32'd0);

        // Full with pop and push in the same cycle: push is still dropped
        wr_en    = 1'b1;
        wr_data  = 16'hBAD0;
        rd_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        check("fp_ovf",   32'(wr_ovf), 32'd1);
        check("fp_full",  32'(full),   32'd0);
        check("fp_count", 32'(count),  32'd9);

        // Drain remaining words, expect 0x0101..0x0109 in order
        n = 1;
        for (int c = 0; c < 40 && n < 10; c++) begin
            if (rd_valid) begin
                check("drain_data", 32'(rd_data), 32'h0100 + 32'(n));
                n++;
            end
            tick();
        end
        rd_ready = 1'b0;
        check("drain_n",     32'(n),        32'd10);
        check("drain_count", 32'(count),    32'd0);
        check("drain_valid", 32'(rd_valid), 32'd0);

        // Streaming 20 words with rd_ready held high; pointers wrap twice
        n        = 0;
        p        = 0;
        first_c  = -1;
        last_c   = -1;
        rd_ready = 1'b1;
        for (int c = 0; c < 80 && n < 20; c++) begin
            if (rd_valid) begin
                check("stream_data", 32'(rd_data), 32'(n));
                if (first_c < 0) first_c = c;
                last_c = c;
                n++;
            end
            wr_en   = (p < 20);
            wr_data = 16'(p);
            if (wr_en && !full) p++;
            tick();
        end
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        check("stream_n",    32'(n),               32'd20);
        check("stream_rate", 32'(last_c - first_c), 32'd19);
        check("stream_cnt",  32'(count),           32'd0);

        // rd_ready toggling every cycle, 16-word stream
        n      = 0;
        p      = 0;
        maxocc = 0;
        for (int c = 0; c < 200 && n < 16; c++) begin
            rd_ready = 1'((c & 1) == 1);
            wr_en    = (p < 16);
            wr_data  = 16'h0200 + 16'(p);
            if (rd_valid && rd_ready) begin
                check("tog_data", 32'(rd_data), 32'h0200 + 32'(n));
                n++;
            end
            if (wr_en && !full) p++;
            if (int'(dut.occ) > maxocc) maxocc = int'(dut.occ);
            tick();
        end
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        check("tog_n",      32'(n),           32'd16);
        check("tog_occmax", 32'(maxocc <= 2), 32'd1);
        check("tog_count",  32'(count),       32'd0);

        // Build count=5 with a read in flight, then reset mid-operation
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h0300 + 16'(i);
            tick();
        end
        wr_data  = 16'h0305;
        rd_ready = 1'b1;
        tick();
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        check("mid_count",    32'(count),        32'd5);
        check("mid_inflight", 32'(dut.inflight), 32'd1);
        rst = 1'b1;
        tick();
        check("mrst_valid",  32'(rd_valid), 32'd0);
        check("mrst_count",  32'(count),    32'd0);
        check("mrst_mem_re", 32'(mem_re),   32'd0);
        rst     = 1'b0;
        wr_en   = 1'b1;
        wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        check("post_valid", 32'(rd_valid), 32'd1);
        check("post_data",  32'(rd_data),  32'hBEEF);
        check("post_count", 32'(count),    32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
